// File: rtl/mem_port_arbiter_m1t_pkg.sv
// mem_arb_pkg_m1t: shared types and widths for the M1T memory port arbiter
package mem_arb_pkg_m1t;
  localparam int MEM_ADDR_W = 15;
  localparam int MEM_DATA_W = 16;
  typedef enum logic [1:0] {READ, WRITE, FENCE0, FENCE1} mode_e;
  typedef enum logic {OWN_C, OWN_D} owner_e;
  typedef enum logic {ARB, FENCE} arb_state_e;
  typedef struct packed {
    logic [MEM_ADDR_W-1:0] addr;
    logic [1:0]            mask;
    logic [1:0]            fnc;
    logic [MEM_DATA_W-1:0] wdata;
    mode_e                 mode;
    logic [3:0]            wb_dest;
  } mem_req_t;
  function automatic logic is_fence(input mode_e m);
    return m inside {FENCE0, FENCE1};
  endfunction
endpackage

// File: rtl/mem_port_arbiter_m1t_if.sv
// mem_port_arbiter_m1t_if: one requester's request/response port into the arbiter
interface mem_port_arbiter_m1t_if #(
  parameter int ADDR_W = 15,
  parameter int DATA_W = 16
);
  logic              req_en;
  logic [ADDR_W-1:0] addr;
  logic [1:0]        mask;
  logic [1:0]        fnc;
  logic [DATA_W-1:0] wdata;
  logic [1:0]        mode;
  logic [3:0]        wb_dest;
  logic              grant;
  logic [DATA_W-1:0] rdata;
  logic [3:0]        rd_wb_dest;
  logic              read_ack;
  modport master (
    output req_en, addr, mask, fnc, wdata, mode, wb_dest,
    input  grant, rdata, rd_wb_dest, read_ack
  );
  modport slave (
    input  req_en, addr, mask, fnc, wdata, mode, wb_dest,
    output grant, rdata, rd_wb_dest, read_ack
  );
endinterface

// File: rtl/mem_port_arbiter_m1t_pick.sv
// mem_arb_pick_m1t: core-first selection with forced debug win once starved
module mem_arb_pick_m1t
  import mem_arb_pkg_m1t::*;
#(
  parameter int STARVE_LIMIT = 4
) (
  input  logic       c_valid,
  input  logic       d_valid,
  input  logic [3:0] starve_cnt,
  output owner_e     win
);
  // D wins when alone or when C has starved it for STARVE_LIMIT grants
  always_comb win = (d_valid && (!c_valid || starve_cnt == 4'(STARVE_LIMIT))) ? OWN_D : OWN_C;
endmodule

// File: rtl/mem_port_arbiter_m1t.sv
// mem_port_arbiter_m1t: shares the single-port M1T memory controller between core and debug ports
module mem_port_arbiter_m1t
  import mem_arb_pkg_m1t::*;
#(
  parameter int ADDR_W       = MEM_ADDR_W,
  parameter int DATA_W       = MEM_DATA_W,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                   clk,
  input  logic                   sync_rst,
  input  logic                   clk_en,
  mem_port_arbiter_m1t_if.slave  c,
  mem_port_arbiter_m1t_if.slave  d,
  output logic [ADDR_W-1:0]      mem_addr,
  output logic [1:0]             mem_mask,
  output logic [1:0]             mem_fnc,
  output logic [DATA_W-1:0]      mem_wdata,
  output logic [1:0]             mem_mode,
  output logic [3:0]             mem_wb_dest,
  output logic                   mem_enable,
  output logic                   mem_input_ready,
  input  logic [DATA_W-1:0]      mem_rdata,
  input  logic [3:0]             mem_rd_wb_dest,
  input  logic                   mem_read_ack,
  input  logic                   mem_available,
  input  logic                   mem_idle
);
  arb_state_e state_q, state_d;
  logic [3:0] starve_cnt_q, starve_cnt_d;
  logic       resp_valid_q, resp_valid_d;
  owner_e     resp_owner_q, resp_owner_d, win;
  mem_req_t   c_req, d_req, mem_req;
  logic       go, gnt;

  mem_arb_pick_m1t #(.STARVE_LIMIT(STARVE_LIMIT)) u_pick (
    .c_valid    (c.req_en),
    .d_valid    (d.req_en),
    .starve_cnt (starve_cnt_q),
    .win        (win)
  );

  // Same-cycle grant and winner mux onto the controller request bus
  always_comb begin
    c_req = '{addr: c.addr, mask: c.mask, fnc: c.fnc, wdata: c.wdata, mode: mode_e'(c.mode), wb_dest: c.wb_dest};
    d_req = '{addr: d.addr, mask: d.mask, fnc: d.fnc, wdata: d.wdata, mode: mode_e'(d.mode), wb_dest: d.wb_dest};
    go = !sync_rst && clk_en && mem_available && state_q == ARB;
    c.grant = go && c.req_en && win == OWN_C;
    d.grant = go && d.req_en && win == OWN_D;
    gnt = c.grant || d.grant;
    mem_req = gnt ? ((win == OWN_D) ? d_req : c_req) : '0;
    mem_addr = mem_req.addr;
    mem_mask = mem_req.mask;
    mem_fnc = mem_req.fnc;
    mem_wdata = mem_req.wdata;
    mem_mode = mem_req.mode;
    mem_wb_dest = mem_req.wb_dest;
    mem_enable = gnt;
    mem_input_ready = gnt;
  end

  // Fence FSM, starvation counter and read-owner tracking; all hold while clk_en is low
  always_comb begin
    state_d = state_q;
    starve_cnt_d = starve_cnt_q;
    resp_valid_d = resp_valid_q;
    resp_owner_d = resp_owner_q;
    if (clk_en) begin
      resp_valid_d = gnt && mem_req.mode == READ;
      resp_owner_d = win;
      if (state_q == ARB && mem_available)
        starve_cnt_d = (d.grant || !d.req_en) ? 4'd0 :
                       (c.grant && starve_cnt_q != 4'(STARVE_LIMIT)) ? starve_cnt_q + 4'd1 : starve_cnt_q;
      state_d = (state_q == ARB) ? ((gnt && is_fence(mem_req.mode)) ? FENCE : ARB) :
                ((mem_idle && !resp_valid_q) ? ARB : FENCE);
    end
  end

  // Route the one-cycle-late read response to whichever port issued it
  always_comb begin
    c.read_ack = !sync_rst && mem_read_ack && resp_valid_q && resp_owner_q == OWN_C;
    d.read_ack = !sync_rst && mem_read_ack && resp_valid_q && resp_owner_q == OWN_D;
    c.rdata = (!sync_rst && resp_owner_q == OWN_C) ? mem_rdata : '0;
    d.rdata = (!sync_rst && resp_owner_q == OWN_D) ? mem_rdata : '0;
    c.rd_wb_dest = (!sync_rst && resp_owner_q == OWN_C) ? mem_rd_wb_dest : '0;
    d.rd_wb_dest = (!sync_rst && resp_owner_q == OWN_D) ? mem_rd_wb_dest : '0;
  end

  // State registers with synchronous reset
  always_ff @(posedge clk) begin
    if (sync_rst) begin
      state_q <= ARB;
      starve_cnt_q <= '0;
      resp_valid_q <= 1'b0;
      resp_owner_q <= OWN_C;
    end else begin
      state_q <= state_d;
      starve_cnt_q <= starve_cnt_d;
      resp_valid_q <= resp_valid_d;
      resp_owner_q <= resp_owner_d;
    end
  end
endmodule

// File: doc/mem_port_arbiter_m1t.md
Name: mem_port_arbiter_m1t

Overview:
- Shares the single-port M1T SoC memory controller (RAM + GPIO window) between two requesters: the core (C) and a debug/DMA port (D).
- Sits between both requesters and the controller's request/response interface. The controller accepts one access per enabled cycle and returns read data exactly one enabled cycle later.
- The arbiter selects one requester per cycle and routes each read response back to its owner. It also serialises fences.

Parameters:
- ADDR_W, 15, request address width
- DATA_W, 16, data width
- STARVE_LIMIT, 4, consecutive C wins while D is waiting before D is forced ahead (range 1..15)

Ports:
- clk  in  1  system clock
- sync_rst  in  1  reset, synchronous, active-high
- clk_en  in  1  global clock enable; all state holds when low
- {c,d}_req_en  in  1  request valid, per requester
- {c,d}_addr  in  ADDR_W  address
- {c,d}_mask  in  2  byte-lane mask
- {c,d}_fnc  in  2  read data type / fence type
- {c,d}_wdata  in  DATA_W  write data
- {c,d}_mode  in  2  0=READ, 1=WRITE, 2/3=FENCE
- {c,d}_wb_dest  in  4  writeback tag
- {c,d}_grant  out  1  request accepted this cycle
- {c,d}_rdata  out  DATA_W  read data
- {c,d}_rd_wb_dest  out  4  returned writeback tag
- {c,d}_read_ack  out  1  read response valid
- mem_addr/mask/fnc/wdata/mode/wb_dest  out  as requester  muxed request to the controller
- mem_enable  out  1  request valid to the controller
- mem_input_ready  out  1  issue strobe; asserted together with mem_enable
- mem_rdata  in  DATA_W  controller read data
- mem_rd_wb_dest  in  4  controller writeback tag
- mem_read_ack  in  1  controller read response valid
- mem_available  in  1  controller can accept a request
- mem_idle  in  1  controller has nothing in flight

Behaviour:
- Acceptance:
  - x_grant = x_req_en && selected(x) && mem_available && state==ARB && clk_en.
  - The grant is combinational; the request is consumed on the same clk edge.
- Downstream request:
  - mem_enable = mem_input_ready = OR of the grants.
  - mem_* fields are muxed from the winner and driven to 0 when there is no grant.
- Selection in ARB:
  - If only one requester is valid, it wins.
  - If both are valid, C wins unless starve_cnt == STARVE_LIMIT, in which case D wins.
- starve_cnt (4b):
  - Increments on each C grant while d_req_en is high; saturates at STARVE_LIMIT.
  - Clears on a D grant, or when d_req_en is low.
- Owner tracking:
  - At each clk_en edge, resp_valid <= (grant && mode==READ) and resp_owner <= winner.
  - Non-read cycles and cycles with no grant clear resp_valid.
- Response routing:
  - x_read_ack = mem_read_ack && resp_valid && resp_owner==x.
  - x_rdata and x_rd_wb_dest = mem value when resp_owner==x, else 0.
  - mem_read_ack without resp_valid is dropped.
- Fences:
  - A winning request with mode[1]=1 is granted and forwarded, then FSM goes ARB -> FENCE.
  - In FENCE, both grants are 0 and starve_cnt holds.
  - FENCE -> ARB when mem_idle && !resp_valid; earliest is 2 enabled cycles after the fence grant.
- States: ARB, FENCE. Reset state is ARB.
- Back-to-back reads are legal every cycle, including alternating owners; owner tracking updates every enabled cycle.
- clk_en low:
  - Grants are 0 and mem_enable is 0.
  - state, starve_cnt, resp_valid and resp_owner hold.
  - Response outputs are still driven combinationally.
- mem_available low: no grants; counters hold.
- Reset:
  - state=ARB, starve_cnt=0, resp_valid=0, resp_owner=C.
  - All grant, ack and mem_enable outputs are 0; data outputs are 0.
  - Reset during an in-flight read or FENCE discards the response; no ack is issued after reset.
- Illegal mode (C and D fence at once): only the winner's fence is forwarded; the loser retries after FENCE.

Decomposition:
- Package mem_arb_pkg_m1t holds:
  - mode_e (READ, WRITE, FENCE0, FENCE1)
  - owner_e (OWN_C, OWN_D)
  - arb_state_e (ARB, FENCE)
  - mem_req_t struct {addr, mask, fnc, wdata, mode, wb_dest}
- One sub-module, mem_arb_pick_m1t: pure combinational priority/starvation select taking both valids plus starve_cnt and returning the winner.
- The FSM, counters and response routing live in the top module.

Test Plan:
- Reset mid-read: C read issued, sync_rst asserted the next cycle -> c_read_ack and d_read_ack stay 0; state=ARB; starve_cnt=0.
- Single C read: c_addr=0x012, mode=0, wb_dest=5 -> c_grant same cycle; mem_addr=0x012. Next cycle with mem_read_ack, mem_rdata=0xBEEF -> c_read_ack=1, c_rdata=0xBEEF, c_rd_wb_dest=5, d_read_ack=0.
- Starvation: C and D both continuously valid, STARVE_LIMIT=4 -> grant sequence C,C,C,C,D,C,C,C,C,D.
- Alternating owners: reads C@0x10, D@0x20, C@0x30 in consecutive cycles -> acks route C,D,C in the next three cycles with the matching data.
- Fence: D fence granted while mem_idle=0 for 3 cycles -> no grants during those cycles even with c_req_en=1; C granted in the first cycle after mem_idle=1 and resp_valid=0.
- clk_en gating: C write to 0x800 with clk_en=0 for 2 cycles -> no grant and mem_enable=0. Grant occurs in the first cycle clk_en=1, with mem_mask and mem_wdata equal to C's values.
